// File: rtl/sio_niu_resp_tx_pkg.sv
// Shared definitions for the SIO->NIU outbound response transmitter.
// Holds the bus geometry, header field positions, response-type codes,
// the FSM state type, the buffered request record and the lane-parity
// helpers used by the transmitter.
package sio_niu_resp_tx_pkg;

    localparam int SIO_NIU_DW = 128;
    localparam int PARW       = 8;
    localparam int BEATS      = 4;
    localparam int PAY_W      = SIO_NIU_DW * BEATS;

    // Header field placement; every other header bit, including the
    // address field [39:0], is driven as 0.
    localparam int HDR_TYPE_LSB = 122;
    localparam int HDR_TYPE_W   = 6;
    localparam int HDR_TAG_LSB  = 64;
    localparam int HDR_TAG_W    = 16;

    localparam logic [5:0] RTYPE_RD_RESP = 6'h2A;
    localparam logic [5:0] RTYPE_WR_ACK  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } tx_state_e;

    typedef struct packed {
        logic [HDR_TYPE_W-1:0] rtype;
        logic [HDR_TAG_W-1:0]  tag;
        logic                  has_data;
        logic                  inj_err;
        logic [PAY_W-1:0]      data;
    } resp_req_t;

    function automatic logic parity16(input logic [15:0] w, input logic odd);
        return (^w) ^ odd;
    endfunction

    function automatic logic [PARW-1:0] lane_parity(input logic [SIO_NIU_DW-1:0] d,
                                                    input logic                  odd);
        logic [PARW-1:0] p;
        p = '0;
        for (int i = 0; i < PARW; i++) begin
            p[i] = parity16(d[16*i +: 16], odd);
        end
        return p;
    endfunction

    function automatic logic [SIO_NIU_DW-1:0] build_hdr(input logic [HDR_TYPE_W-1:0] rtype,
                                                        input logic [HDR_TAG_W-1:0]  tag);
        logic [SIO_NIU_DW-1:0] h;
        h = '0;
        h[HDR_TYPE_LSB +: HDR_TYPE_W] = rtype;
        h[HDR_TAG_LSB  +: HDR_TAG_W]  = tag;
        return h;
    endfunction

endpackage

// File: rtl/sio_niu_resp_tx_if.sv
// Request-side handshake and NIU-side outbound bus of the response
// transmitter, bundled so the design and its environment share one view.
//   req_vld/req_rdy       request handshake (transfer when both high)
//   req_type/tag/...      request fields, sampled on transfer
//   inj_par_err           corrupt payload parity of the transferred packet
//   sio_niu_*             registered header/payload bus toward the NIU
//   tx_busy, pkt_done     status
// slave  : the transmitter's view
// master : the request source / NIU-side observer's view
interface sio_niu_resp_tx_if;
    import sio_niu_resp_tx_pkg::*;

    logic                  req_vld;
    logic                  req_rdy;
    logic [HDR_TYPE_W-1:0] req_type;
    logic [HDR_TAG_W-1:0]  req_tag;
    logic                  req_has_data;
    logic [PAY_W-1:0]      req_data;
    logic                  inj_par_err;

    logic                  sio_niu_hdr_vld;
    logic                  sio_niu_datareq;
    logic [SIO_NIU_DW-1:0] sio_niu_data;
    logic [PARW-1:0]       sio_niu_parity;
    logic                  tx_busy;
    logic                  pkt_done;

    modport slave (
        input  req_vld, req_type, req_tag, req_has_data, req_data, inj_par_err,
        output req_rdy, sio_niu_hdr_vld, sio_niu_datareq, sio_niu_data,
               sio_niu_parity, tx_busy, pkt_done
    );

    modport master (
        output req_vld, req_type, req_tag, req_has_data, req_data, inj_par_err,
        input  req_rdy, sio_niu_hdr_vld, sio_niu_datareq, sio_niu_data,
               sio_niu_parity, tx_busy, pkt_done
    );

endinterface

// File: rtl/sio_niu_resp_tx_req_fifo.sv
// Synchronous request FIFO for the response transmitter.
//   iol2clk, reset   clock, synchronous active-high reset (flushes entries)
//   i_push, i_wdata  write request; ignored while full
//   i_pop            drop the head entry; ignored while empty
//   o_rdata          head entry (valid when !o_empty)
//   o_full, o_empty  occupancy flags
module sio_niu_req_fifo
    import sio_niu_resp_tx_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      iol2clk,
    input  logic      reset,
    input  logic      i_push,
    input  resp_req_t i_wdata,
    input  logic      i_pop,
    output resp_req_t o_rdata,
    output logic      o_full,
    output logic      o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    resp_req_t     r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_wr_en;
    logic          w_rd_en;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge iol2clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge iol2clk) begin
        if (!reset && w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/sio_niu_resp_tx.sv
// SIO->NIU outbound response transmitter. Buffers response requests and
// sends each as one header cycle, followed by four payload beats when the
// response carries data. All NIU-side outputs are registered.
//   iol2clk   clock, all logic on its rising edge
//   reset     synchronous active-high reset; truncates any packet in flight
//   bus       request handshake in, sio_niu_* bus and status out
// Parameters: DEPTH request entries (power of 2, >=2); PAR_ODD selects odd
// lane parity.
//
// state   | meaning
// IDLE    | nothing on the bus, waiting for a buffered request
// HDR     | header cycle on the bus (request was popped on entry)
// PAY     | payload beat r_beat (0..3) on the bus
module sio_niu_resp_tx
    import sio_niu_resp_tx_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter bit PAR_ODD = 1'b0
) (
    input  logic               iol2clk,
    input  logic               reset,
    sio_niu_resp_tx_if.slave   bus
);

    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    tx_state_e             r_state;
    tx_state_e             w_nxt_state;
    logic [1:0]            r_beat;
    logic [1:0]            w_nxt_beat;
    resp_req_t             r_cur;
    resp_req_t             w_cur_nxt;
    resp_req_t             w_head;
    resp_req_t             w_wdata;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;

    logic                  r_hdr_vld;
    logic                  r_datareq;
    logic [SIO_NIU_DW-1:0] r_data;
    logic [PARW-1:0]       r_parity;
    logic                  r_pkt_done;

    logic                  w_hdr_vld_d;
    logic                  w_datareq_d;
    logic [SIO_NIU_DW-1:0] w_data_d;
    logic [PARW-1:0]       w_parity_d;
    logic                  w_pkt_done_d;
    logic                  w_flip_d;
    logic [SIO_NIU_DW-1:0] w_beat_data;

    assign w_wdata = '{rtype:    bus.req_type,
                       tag:      bus.req_tag,
                       has_data: bus.req_has_data,
                       inj_err:  bus.inj_par_err,
                       data:     bus.req_data};
    assign w_push  = bus.req_vld && !w_full;

    sio_niu_req_fifo #(.DEPTH(DEPTH)) u_req_fifo (
        .iol2clk (iol2clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.req_rdy = !w_full;
    assign bus.tx_busy = !w_empty || (r_state != ST_IDLE);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_beat  = r_beat;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_nxt_state = ST_HDR;
                    w_pop       = 1'b1;
                end
            end
            ST_HDR: begin
                if (r_cur.has_data) begin
                    w_nxt_state = ST_PAY;
                    w_nxt_beat  = '0;
                end else if (!w_empty) begin
                    w_nxt_state = ST_HDR;
                    w_pop       = 1'b1;
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_PAY: begin
                if (r_beat == LAST_BEAT) begin
                    if (!w_empty) begin
                        w_nxt_state = ST_HDR;
                        w_pop       = 1'b1;
                    end else begin
                        w_nxt_state = ST_IDLE;
                    end
                end else begin
                    w_nxt_beat = r_beat + 2'd1;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    // The packet owning the next bus cycle: freshly popped head on a
    // header launch, otherwise the packet already in flight.
    assign w_cur_nxt = w_pop ? w_head : r_cur;

    always_comb begin
        w_beat_data = '0;
        case (w_nxt_beat)
            2'd0: w_beat_data = w_cur_nxt.data[0*SIO_NIU_DW +: SIO_NIU_DW];
            2'd1: w_beat_data = w_cur_nxt.data[1*SIO_NIU_DW +: SIO_NIU_DW];
            2'd2: w_beat_data = w_cur_nxt.data[2*SIO_NIU_DW +: SIO_NIU_DW];
            2'd3: w_beat_data = w_cur_nxt.data[3*SIO_NIU_DW +: SIO_NIU_DW];
            default: w_beat_data = '0;
        endcase
    end

    // Output register inputs are derived from the next state so the bus
    // shows exactly what the FSM will be in after the edge.
    always_comb begin
        w_hdr_vld_d  = 1'b0;
        w_datareq_d  = 1'b0;
        w_data_d     = '0;
        w_parity_d   = '0;
        w_pkt_done_d = 1'b0;
        w_flip_d     = 1'b0;
        case (w_nxt_state)
            ST_HDR: begin
                w_hdr_vld_d  = 1'b1;
                w_datareq_d  = w_cur_nxt.has_data;
                w_data_d     = build_hdr(w_cur_nxt.rtype, w_cur_nxt.tag);
                w_pkt_done_d = !w_cur_nxt.has_data;
            end
            ST_PAY: begin
                w_data_d     = w_beat_data;
                w_flip_d     = w_cur_nxt.inj_err;
                w_pkt_done_d = (w_nxt_beat == LAST_BEAT);
            end
            default: ;
        endcase
        if (w_nxt_state != ST_IDLE) begin
            w_parity_d = lane_parity(w_data_d, PAR_ODD) ^ {{(PARW-1){1'b0}}, w_flip_d};
        end
    end

    always_ff @(posedge iol2clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_beat     <= '0;
            r_cur      <= '0;
            r_hdr_vld  <= 1'b0;
            r_datareq  <= 1'b0;
            r_data     <= '0;
            r_parity   <= '0;
            r_pkt_done <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_beat     <= w_nxt_beat;
            r_cur      <= w_cur_nxt;
            r_hdr_vld  <= w_hdr_vld_d;
            r_datareq  <= w_datareq_d;
            r_data     <= w_data_d;
            r_parity   <= w_parity_d;
            r_pkt_done <= w_pkt_done_d;
        end
    end

    assign bus.sio_niu_hdr_vld = r_hdr_vld;
    assign bus.sio_niu_datareq = r_datareq;
    assign bus.sio_niu_data    = r_data;
    assign bus.sio_niu_parity  = r_parity;
    assign bus.pkt_done        = r_pkt_done;

endmodule

// File: tb/tb_sio_niu_resp_tx.sv
`timescale 1ns/1ps
module tb_sio_niu_resp_tx;
    import sio_niu_resp_tx_pkg::*;

    localparam int DEPTH = 2;

    logic iol2clk = 1'b0;
    logic reset;
    always #5 iol2clk = ~iol2clk;

    sio_niu_resp_tx_if bus0 ();
    sio_niu_resp_tx_if bus1 ();

    sio_niu_resp_tx #(.DEPTH(DEPTH), .PAR_ODD(1'b0)) u_dut_even (
        .iol2clk (iol2clk),
        .reset   (reset),
        .bus     (bus0)
    );

    sio_niu_resp_tx #(.DEPTH(DEPTH), .PAR_ODD(1'b1)) u_dut_odd (
        .iol2clk (iol2clk),
        .reset   (reset),
        .bus     (bus1)
    );

    assign bus1.req_vld      = bus0.req_vld;
    assign bus1.req_type     = bus0.req_type;
    assign bus1.req_tag      = bus0.req_tag;
    assign bus1.req_has_data = bus0.req_has_data;
    assign bus1.req_data     = bus0.req_data;
    assign bus1.inj_par_err  = bus0.inj_par_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    always @(posedge iol2clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    // One expected bus cycle. A header may not appear before 'ready';
    // payload beats must follow their header with no gap.
    typedef struct {
        logic         hdr;
        logic         dreq;
        logic [127:0] data;
        logic [7:0]   par;
        logic         done;
        int           ready;
    } beat_t;

    beat_t exp_q[$];
    int    pending = 0;

    function automatic logic [7:0] even_par(input logic [127:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
        return p;
    endfunction

    task automatic push_expected(input logic [5:0] t, input logic [15:0] tag, input logic hd,
                                 input logic [511:0] d, input logic inj, input int rdy);
        beat_t b;
        b.hdr   = 1'b1;
        b.dreq  = hd;
        b.data  = '0;
        b.data[127:122] = t;
        b.data[79:64]   = tag;
        b.par   = even_par(b.data);
        b.done  = !hd;
        b.ready = rdy;
        exp_q.push_back(b);
        if (hd) begin
            for (int k = 0; k < 4; k++) begin
                b.hdr   = 1'b0;
                b.dreq  = 1'b0;
                b.data  = d[128*k +: 128];
                b.par   = even_par(b.data) ^ {7'b0, inj};
                b.done  = (k == 3);
                b.ready = 0;
                exp_q.push_back(b);
            end
        end
        pending++;
    endtask

    always @(negedge iol2clk) begin
        beat_t e;
        logic  drv;
        if (mon_en) begin
            drv = (exp_q.size() > 0) && (exp_q[0].ready <= cyc);
            if (drv) begin
                e = exp_q.pop_front();
                if (e.hdr) pending--;
            end else begin
                e.hdr = 1'b0; e.dreq = 1'b0; e.data = '0; e.par = '0; e.done = 1'b0; e.ready = 0;
            end
            check_eq("hdr_vld",     bus0.sio_niu_hdr_vld, e.hdr);
            check_eq("datareq",     bus0.sio_niu_datareq, e.dreq);
            check_eq("data",        bus0.sio_niu_data,    e.data);
            check_eq("parity",      bus0.sio_niu_parity,  e.par);
            check_eq("pkt_done",    bus0.pkt_done,        e.done);
            check_eq("req_rdy",     bus0.req_rdy,         pending < DEPTH);
            check_eq("tx_busy",     bus0.tx_busy,         (pending > 0) || drv);
            check_eq("odd_hdr_vld", bus1.sio_niu_hdr_vld, e.hdr);
            check_eq("odd_datareq", bus1.sio_niu_datareq, e.dreq);
            check_eq("odd_data",    bus1.sio_niu_data,    e.data);
            check_eq("odd_parity",  bus1.sio_niu_parity,  drv ? (e.par ^ 8'hFF) : 8'h00);
            check_eq("odd_done",    bus1.pkt_done,        e.done);
            check_eq("odd_rdy",     bus1.req_rdy,         pending < DEPTH);
            check_eq("odd_busy",    bus1.tx_busy,         (pending > 0) || drv);
            if (reset) begin
                exp_q.delete();
                pending = 0;
            end else if (bus0.req_vld && bus0.req_rdy) begin
                push_expected(bus0.req_type, bus0.req_tag, bus0.req_has_data,
                              bus0.req_data, bus0.inj_par_err, cyc + 2);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [5:0] t, input logic [15:0] tag, input logic hd,
                        input logic [511:0] d, input logic inj);
        bit acc;
        int guard;
        acc   = 1'b0;
        guard = 0;
        bus0.req_vld      = 1'b1;
        bus0.req_type     = t;
        bus0.req_tag      = tag;
        bus0.req_has_data = hd;
        bus0.req_data     = d;
        bus0.inj_par_err  = inj;
        do begin
            @(negedge iol2clk);
            acc = bus0.req_rdy;
            @(posedge iol2clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        check_eq("send_accept", acc, 1'b1);
        bus0.req_vld     = 1'b0;
        bus0.inj_par_err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge iol2clk);
            #1;
        end
    endtask

    function automatic logic [511:0] rand_data();
        logic [511:0] d;
        for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom();
        return d;
    endfunction

    initial begin
        logic [511:0] d;
        int guard;
        reset             = 1'b1;
        bus0.req_vld      = 1'b0;
        bus0.req_type     = '0;
        bus0.req_tag      = '0;
        bus0.req_has_data = 1'b0;
        bus0.req_data     = '0;
        bus0.inj_par_err  = 1'b0;
        repeat (3) @(posedge iol2clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // single read response, beat k lanes all hold k+1
        for (int k = 0; k < 4; k++) d[128*k +: 128] = {8{16'(k + 1)}};
        send(RTYPE_RD_RESP, 16'h1234, 1'b1, d, 1'b0);
        idle(8);

        // write ack, header only
        send(RTYPE_WR_ACK, 16'hBEEF, 1'b0, '0, 1'b0);
        idle(4);

        // back-to-back pushes, FIFO fills and stalls the fourth
        send(6'h2A, 16'h0001, 1'b1, rand_data(), 1'b0);
        send(6'h2A, 16'h0002, 1'b1, rand_data(), 1'b0);
        send(6'h2B, 16'h0003, 1'b0, '0, 1'b0);
        send(6'h2A, 16'h0004, 1'b1, rand_data(), 1'b0);
        idle(20);

        // reset during PAY1, then a clean restart
        send(6'h2A, 16'h0A0A, 1'b1, rand_data(), 1'b0);
        idle(3);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(2);
        send(6'h2B, 16'h0B0B, 1'b0, '0, 1'b0);
        idle(4);

        // injected parity error on a data packet
        send(6'h2A, 16'h0C0C, 1'b1, rand_data(), 1'b1);
        idle(8);

        // random mixed stream
        for (int p = 0; p < 100; p++) begin
            logic hd;
            hd = 1'($urandom_range(0, 1));
            send(6'($urandom_range(0, 63)), 16'($urandom()), hd, rand_data(),
                 1'($urandom_range(0, 3) == 0));
            idle($urandom_range(0, 3));
        end

        guard = 0;
        while ((exp_q.size() > 0 || pending > 0) && guard < 400) begin
            idle(1);
            guard++;
        end
        check_eq("drain", 128'(exp_q.size()), 128'd0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
